imem_boot_ctrl: RTL and testbench

- Synthesizable program-load and run controller for the single-cycle RISC-V core with FPU.
- Clears the register file, streams a program into instruction memory over a valid/ready port, and holds then releases core reset.
- Watches the core PC for a self-loop halt or a watchdog timeout, then reports pass/timeout and the cycle count.
- Sits beside `top` as the in-system replacement for bench-side memory loading, register clearing and PC monitoring.

---
 rtl/imem_boot_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Program-load and run controller: clears the register file, streams a program into
// instruction memory, releases core reset and watches the PC for a halt or watchdog expiry.
module imem_boot_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 32,
    parameter int RST_HOLD    = 2,
    parameter int HALT_STABLE = 4,
    parameter int MAX_CYCLES  = 1000,
    parameter int CNT_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              core_rst,
    input  logic [DATA_W-1:0] core_pc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [4:0]        CLR_LAST   = 5'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   LOAD_LAST  = (ADDR_W + 1)'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W:0]   LOAD_INC   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [15:0]       HOLD_LAST  = 16'(RST_HOLD - 1);
    localparam logic [15:0]       STABLE_LIM = 16'(HALT_STABLE);
    localparam logic [CNT_W-1:0]  CYCLE_LIM  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CYCLE_INC  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [4:0]          clr_idx_q, clr_idx_d;
    logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
    logic [15:0]         hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [15:0]         stable_q, stable_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   prev_pc_q, prev_pc_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         stable_nxt_s;
    logic [CNT_W-1:0]    cycle_nxt_s;

    // Next-state and datapath update for the boot/run sequencer.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        load_cnt_d   = load_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_d      = cycle_q;
        stable_d     = stable_q;
        first_d      = first_q;
        prev_pc_d    = core_pc;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        stable_nxt_s = 16'd0;
        cycle_nxt_s  = cycle_q + CYCLE_INC;

        // The first RUN cycle has no valid previous PC to compare against.
        if (!first_q && (core_pc == prev_pc_q)) begin
            stable_nxt_s = stable_q + 16'd1;
        end else begin
            stable_nxt_s = 16'd0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    clr_idx_d  = 5'd0;
                    load_cnt_d = {(ADDR_W+1){1'b0}};
                    cycle_d    = {CNT_W{1'b0}};
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_CLEAR: begin
                if (clr_idx_q == CLR_LAST) begin
                    state_d    = S_LOAD;
                    clr_idx_d  = 5'd0;
                    load_cnt_d = {(ADDR_W+1){1'b0}};
                end else begin
                    clr_idx_d = clr_idx_q + 5'd1;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = load_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = ld_data;
                    load_cnt_d   = load_cnt_q + LOAD_INC;
                    // A full memory ends the load even without ld_last.
                    if (ld_last || (load_cnt_q == LOAD_LAST)) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = 16'd0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d  = S_RUN;
                    first_d  = 1'b1;
                    stable_d = 16'd0;
                    cycle_d  = {CNT_W{1'b0}};
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                cycle_d  = cycle_nxt_s;
                first_d  = 1'b0;
                stable_d = stable_nxt_s;
                // Halt is checked first so it wins a tie with the watchdog.
                if (stable_nxt_s == STABLE_LIM) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (cycle_nxt_s == CYCLE_LIM) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            clr_idx_q    <= 5'd0;
            load_cnt_q   <= {(ADDR_W+1){1'b0}};
            hold_cnt_q   <= 16'd0;
            cycle_q      <= {CNT_W{1'b0}};
            stable_q     <= 16'd0;
            first_q      <= 1'b0;
            prev_pc_q    <= {DATA_W{1'b0}};
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= {DATA_W{1'b0}};
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            load_cnt_q   <= load_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_q      <= cycle_d;
            stable_q     <= stable_d;
            first_q      <= first_d;
            prev_pc_q    <= prev_pc_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ld_ready     = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign core_rst     = (state_q != S_RUN);
    assign rf_we        = (state_q == S_CLEAR);
    assign rf_addr      = clr_idx_q;
    assign rf_wdata     = {DATA_W{1'b0}};
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_q;
    assign words_loaded = load_cnt_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: instance 0 uses an 8-bit address and a 20-cycle watchdog,
// instance 1 a 4-word memory and a 5-cycle watchdog so halt and watchdog can coincide.
module tb_imem_boot_ctrl;

    localparam int HS   = 4;
    localparam int NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  start_v, ldv_v, last_v;
    logic [31:0] ldd_v [2];
    logic [31:0] pc_v  [2];

    wire [1:0]  rdy_v, ime_v, rfwe_v, crst_v, busy_v, done_v, pass_v, to_v;
    wire [7:0]  ima_v [2];
    wire [31:0] imd_v [2];
    wire [31:0] rfd_v [2];
    wire [31:0] cyc_v [2];
    wire [4:0]  rfa_v [2];
    wire [8:0]  wl_v  [2];
    wire [1:0]  b_ima;
    wire [2:0]  b_wl;
    assign ima_v[1] = {6'd0, b_ima};
    assign wl_v[1]  = {6'd0, b_wl};

    int checks = 0;
    int errors = 0;

    imem_boot_ctrl #(.MAX_CYCLES(20)) dut_a (
        .CLK(clk), .RST(rst), .start(start_v[0]), .ld_valid(ldv_v[0]), .ld_ready(rdy_v[0]),
        .ld_data(ldd_v[0]), .ld_last(last_v[0]), .imem_we(ime_v[0]), .imem_addr(ima_v[0]),
        .imem_wdata(imd_v[0]), .rf_we(rfwe_v[0]), .rf_addr(rfa_v[0]), .rf_wdata(rfd_v[0]),
        .core_rst(crst_v[0]), .core_pc(pc_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .timeout(to_v[0]), .cycle_count(cyc_v[0]), .words_loaded(wl_v[0])
    );

    imem_boot_ctrl #(.ADDR_W(2), .MAX_CYCLES(5)) dut_b (
        .CLK(clk), .RST(rst), .start(start_v[1]), .ld_valid(ldv_v[1]), .ld_ready(rdy_v[1]),
        .ld_data(ldd_v[1]), .ld_last(last_v[1]), .imem_we(ime_v[1]), .imem_addr(b_ima),
        .imem_wdata(imd_v[1]), .rf_we(rfwe_v[1]), .rf_addr(rfa_v[1]), .rf_wdata(rfd_v[1]),
        .core_rst(crst_v[1]), .core_pc(pc_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .timeout(to_v[1]), .cycle_count(cyc_v[1]), .words_loaded(b_wl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
    endtask

    function automatic logic [31:0] pc_at(input logic [31:0] q[$], input int k);
        if (k < q.size()) return q[k];
        return q[q.size()-1];
    endfunction

    // Reference: halt once the PC has repeated HS times in a row, else expire at maxc.
    function automatic void model_run(input logic [31:0] q[$], input int maxc,
                                      output bit p, output bit t, output int cyc);
        int run = 0;
        p = 1'b0; t = 1'b0; cyc = 0;
        for (int n = 1; n <= maxc; n++) begin
            if (n > 1 && pc_at(q, n-1) == pc_at(q, n-2)) run++;
            else run = 0;
            if (run == HS) begin p = 1'b1; cyc = n; return; end
            if (n == maxc) begin t = 1'b1; cyc = n; return; end
        end
    endfunction

    // Start, clear, load n words with random backpressure, wait for core release.
    task automatic boot(input int d, input int nwords);
        int i = 0;
        int g = 0;
        pulse_start(d);
        repeat (NREG) step();
        for (int guard = 0; guard < 200; guard++) begin
            if (i == nwords) break;
            ldv_v[d]  = 1'($urandom_range(0, 1));
            ldd_v[d]  = $urandom;
            last_v[d] = (i == nwords - 1);
            if (ldv_v[d] && rdy_v[d]) i++;
            step();
        end
        ldv_v[d] = 1'b0; last_v[d] = 1'b0;
        while (crst_v[d] === 1'b1 && g < 20) begin g++; step(); end
        checks++;
        if (crst_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL boot_release dut%0d: core_rst=%b required 0 within budget", d, crst_v[d]);
        end
    endtask

    task automatic run_pcs(input int d, input logic [31:0] q[$], input int start_at, output int n);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            pc_v[d]    = pc_at(q, k-1);
            start_v[d] = (k == start_at);
            step();
            start_v[d] = 1'b0;
            if (done_v[d] === 1'b1) begin n = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({crst_v[d], busy_v[d], done_v[d], pass_v[d], to_v[d], rdy_v[d], ime_v[d], rfwe_v[d]} !== 8'b1000_0000
                || cyc_v[d] !== 32'd0 || wl_v[d] !== 9'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: flags=%b cyc=%0d wl=%0d required flags=10000000 cyc=0 wl=0",
                         d, {crst_v[d], busy_v[d], done_v[d], pass_v[d], to_v[d], rdy_v[d], ime_v[d], rfwe_v[d]},
                         cyc_v[d], wl_v[d]);
            end
        end
        rst = 1'b0;
        pulse_start(0);
        repeat (NREG) step();
        ldv_v[0] = 1'b1; ldd_v[0] = 32'hDEAD_BEEF;
        step();
        ldv_v[0] = 1'b0;
        step();
        checks++;
        if (wl_v[0] !== 9'd1) begin
            errors++;
            $display("FAIL mid_load_count: got %0d required 1", wl_v[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({crst_v[0], busy_v[0], rdy_v[0], ime_v[0], done_v[0]} !== 5'b10000 || wl_v[0] !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_load: flags=%b wl=%0d required flags=10000 wl=0",
                     {crst_v[0], busy_v[0], rdy_v[0], ime_v[0], done_v[0]}, wl_v[0]);
        end
        step();
        checks++;
        if (busy_v[0] !== 1'b0 || crst_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b core_rst=%b required busy=0 core_rst=1", busy_v[0], crst_v[0]);
        end
    endtask

    task automatic test_clear(input int d);
        pulse_start(d);
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (rfwe_v[d] !== 1'b1 || rfa_v[d] !== i[4:0] || rfd_v[d] !== 32'd0 || busy_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL clear_cycle %0d: we=%b addr=%0d data=%0h busy=%b required we=1 addr=%0d data=0 busy=1",
                         i, rfwe_v[d], rfa_v[d], rfd_v[d], busy_v[d], i);
            end
            step();
        end
        checks++;
        if (rfwe_v[d] !== 1'b0 || rdy_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL clear_to_load: rf_we=%b ld_ready=%b required rf_we=0 ld_ready=1", rfwe_v[d], rdy_v[d]);
        end
    endtask

    task automatic test_load_backpressure(input int d);
        logic [31:0] w [4];
        logic [7:0]  ea [$];
        logic [31:0] ed [$];
        int i = 0, writes = 0, hc = 0;
        w[0] = 32'h0000_0013; w[1] = 32'h0010_0093; w[2] = 32'h0020_8113; w[3] = 32'h0000_006F;
        for (int guard = 0; guard < 200; guard++) begin
            if (ime_v[d] === 1'b1) begin
                checks++; writes++;
                if (ea.size() == 0 || ima_v[d] !== ea[0] || imd_v[d] !== ed[0]) begin
                    errors++;
                    $display("FAIL load_write: addr=%0d data=%h required addr=%0d data=%h",
                             ima_v[d], imd_v[d], ea.size() ? ea[0] : 8'd0, ed.size() ? ed[0] : 32'd0);
                end
                if (ea.size() != 0) begin void'(ea.pop_front()); void'(ed.pop_front()); end
            end
            if (i == 4) break;
            ldv_v[d]  = 1'($urandom_range(0, 1));
            ldd_v[d]  = w[i];
            last_v[d] = (i == 3);
            if (ldv_v[d] && rdy_v[d]) begin ea.push_back(8'(i)); ed.push_back(w[i]); i++; end
            step();
        end
        ldv_v[d] = 1'b0; last_v[d] = 1'b0;
        checks++;
        if (rdy_v[d] !== 1'b0 || wl_v[d] !== 9'd4 || writes != 4) begin
            errors++;
            $display("FAIL load_end: ld_ready=%b words_loaded=%0d writes=%0d required 0/4/4", rdy_v[d], wl_v[d], writes);
        end
        while (crst_v[d] === 1'b1 && hc < 10) begin hc++; step(); end
        checks++;
        if (hc != 2) begin
            errors++;
            $display("FAIL hold_length: got %0d cycles required 2", hc);
        end
    endtask

    task automatic check_run(input int d, input string name, input logic [31:0] q[$], input int maxc, input int n);
        bit p, t;
        int c;
        model_run(q, maxc, p, t, c);
        checks++;
        if ({done_v[d], pass_v[d], to_v[d], crst_v[d], busy_v[d]} !== {1'b1, p, t, 1'b1, 1'b0}
            || cyc_v[d] !== 32'(c) || n != c) begin
            errors++;
            $display("FAIL %s: done/pass/to/rst/busy=%b cyc=%0d at=%0d required %b cyc=%0d at=%0d", name,
                     {done_v[d], pass_v[d], to_v[d], crst_v[d], busy_v[d]}, cyc_v[d], n,
                     {1'b1, p, t, 1'b1, 1'b0}, c, c);
        end
    endtask

    task automatic test_halt(input int d);
        logic [31:0] q [$];
        int n;
        q = {32'h0, 32'h4, 32'h8, 32'hC};
        run_pcs(d, q, 0, n);
        check_run(d, "halt", q, 20, n);
    endtask

    task automatic test_timeout(input int d);
        logic [31:0] q [$];
        int n;
        for (int k = 0; k < 40; k++) q.push_back(32'(k * 4));
        boot(d, 3);
        run_pcs(d, q, 0, n);
        check_run(d, "timeout", q, 20, n);
    endtask

    task automatic test_start_in_run(input int d);
        logic [31:0] q [$];
        logic [31:0] held;
        int n;
        for (int k = 0; k < 6; k++) q.push_back(32'h100 + 32'(k * 4));
        boot(d, 2);
        run_pcs(d, q, 3, n);
        check_run(d, "start_in_run", q, 20, n);
        held = cyc_v[d];
        repeat (3) step();
        checks++;
        if (done_v[d] !== 1'b1 || cyc_v[d] !== held || busy_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b cyc=%0d busy=%b required done=1 cyc=%0d busy=0",
                     done_v[d], cyc_v[d], busy_v[d], held);
        end
    endtask

    task automatic test_random_runs(input int d);
        logic [31:0] q [$];
        int n;
        for (int it = 0; it < 8; it++) begin
            q.delete();
            for (int k = 0; k < $urandom_range(1, 19); k++) q.push_back($urandom);
            boot(d, $urandom_range(1, 6));
            run_pcs(d, q, 0, n);
            check_run(d, "random_run", q, 20, n);
        end
    endtask

    task automatic test_restart(input int d);
        pulse_start(d);
        checks++;
        if ({done_v[d], pass_v[d], to_v[d], rfwe_v[d], busy_v[d], crst_v[d]} !== 6'b000111
            || cyc_v[d] !== 32'd0 || wl_v[d] !== 9'd0 || rfa_v[d] !== 5'd0) begin
            errors++;
            $display("FAIL restart_from_done: flags=%b cyc=%0d wl=%0d rf_addr=%0d required flags=000111 cyc=0 wl=0 rf_addr=0",
                     {done_v[d], pass_v[d], to_v[d], rfwe_v[d], busy_v[d], crst_v[d]}, cyc_v[d], wl_v[d], rfa_v[d]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_full_memory(input int d);
        logic [7:0]  ea [$];
        logic [31:0] ed [$];
        int i = 0, writes = 0, g = 0;
        pulse_start(d);
        repeat (NREG) step();
        for (int guard = 0; guard < 200; guard++) begin
            if (ime_v[d] === 1'b1) begin
                checks++; writes++;
                if (ea.size() == 0 || ima_v[d] !== ea[0] || imd_v[d] !== ed[0]) begin
                    errors++;
                    $display("FAIL full_write: addr=%0d data=%h required addr=%0d data=%h",
                             ima_v[d], imd_v[d], ea.size() ? ea[0] : 8'd0, ed.size() ? ed[0] : 32'd0);
                end
                if (ea.size() != 0) begin void'(ea.pop_front()); void'(ed.pop_front()); end
            end
            if (i == 4) break;
            ldv_v[d]  = 1'($urandom_range(0, 1));
            ldd_v[d]  = $urandom;
            last_v[d] = 1'b0;
            if (ldv_v[d] && rdy_v[d]) begin ea.push_back(8'(i)); ed.push_back(ldd_v[d]); i++; end
            step();
        end
        checks++;
        if (rdy_v[d] !== 1'b0 || wl_v[d] !== 9'd4 || writes != 4) begin
            errors++;
            $display("FAIL full_end: ld_ready=%b words_loaded=%0d writes=%0d required 0/4/4", rdy_v[d], wl_v[d], writes);
        end
        ldv_v[d] = 1'b1;
        step();
        ldv_v[d] = 1'b0;
        checks++;
        if (ime_v[d] !== 1'b0 || wl_v[d] !== 9'd4) begin
            errors++;
            $display("FAIL full_no_extra: imem_we=%b words_loaded=%0d required 0/4", ime_v[d], wl_v[d]);
        end
        while (crst_v[d] === 1'b1 && g < 20) begin g++; step(); end
        checks++;
        if (crst_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL full_release: core_rst=%b required 0", crst_v[d]);
        end
    endtask

    task automatic test_coincide(input int d);
        logic [31:0] q [$];
        int n;
        q = {32'h40};
        run_pcs(d, q, 0, n);
        check_run(d, "halt_watchdog_tie", q, 5, n);
    endtask

    initial begin
        rst = 1'b1;
        start_v = 2'b00; ldv_v = 2'b00; last_v = 2'b00;
        ldd_v[0] = 32'd0; ldd_v[1] = 32'd0; pc_v[0] = 32'd0; pc_v[1] = 32'd0;
        test_reset();
        test_clear(0);
        test_load_backpressure(0);
        test_halt(0);
        test_timeout(0);
        test_start_in_run(0);
        test_random_runs(0);
        test_restart(0);
        test_full_memory(1);
        test_coincide(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
